// File: rtl/idexe_pipe_reg.sv
// ID/EXE pipeline register with load-use hazard detection and a saturating
// stall counter for performance debug.
module idexe_pipe_reg #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dvalid,
    input  logic          wreg,
    input  logic          m2reg,
    input  logic          wmem,
    input  logic          aluimm,
    input  logic [3:0]    aluc,
    input  logic [4:0]    destReg,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic          usesRt,
    input  logic [DW-1:0] qa,
    input  logic [DW-1:0] qb,
    input  logic [DW-1:0] imm32,
    input  logic          flush,
    output logic          ewreg,
    output logic          em2reg,
    output logic          ewmem,
    output logic          ealuimm,
    output logic [3:0]    ealuc,
    output logic [4:0]    edestReg,
    output logic [DW-1:0] eqa,
    output logic [DW-1:0] eqb,
    output logic [DW-1:0] eimm32,
    output logic          evalid,
    output logic          stall,
    output logic [CW-1:0] stallCount
);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == {CW{1'b1}}) ? c : c + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    logic          wreg_q,    wreg_d;
    logic          m2reg_q,   m2reg_d;
    logic          wmem_q,    wmem_d;
    logic          aluimm_q,  aluimm_d;
    logic [3:0]    aluc_q,    aluc_d;
    logic [4:0]    dest_q,    dest_d;
    logic [DW-1:0] qa_q,      qa_d;
    logic [DW-1:0] qb_q,      qb_d;
    logic [DW-1:0] imm_q,     imm_d;
    logic          valid_q,   valid_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          bubble;
    logic          src_match;

    // A load in EXE whose result is needed by the ID instruction; $0 is never a real dependency.
    always_comb begin
        src_match = (dest_q == rs) | (usesRt & (dest_q == rt));
        stall     = dvalid & valid_q & wreg_q & m2reg_q & (dest_q != 5'd0) & src_match;
    end

    always_comb begin
        bubble   = flush | stall;
        wreg_d   = bubble ? 1'b0 : wreg;
        m2reg_d  = bubble ? 1'b0 : m2reg;
        wmem_d   = bubble ? 1'b0 : wmem;
        aluimm_d = bubble ? 1'b0 : aluimm;
        aluc_d   = bubble ? 4'd0 : aluc;
        dest_d   = bubble ? 5'd0 : destReg;
        qa_d     = bubble ? '0 : qa;
        qb_d     = bubble ? '0 : qb;
        imm_d    = bubble ? '0 : imm32;
        valid_d  = bubble ? 1'b0 : dvalid;
        // A flushed cycle is charged to the branch, not to the hazard.
        cnt_d    = (stall & ~flush) ? sat_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wreg_q   <= 1'b0;
            m2reg_q  <= 1'b0;
            wmem_q   <= 1'b0;
            aluimm_q <= 1'b0;
            aluc_q   <= 4'd0;
            dest_q   <= 5'd0;
            qa_q     <= '0;
            qb_q     <= '0;
            imm_q    <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wreg_q   <= wreg_d;
            m2reg_q  <= m2reg_d;
            wmem_q   <= wmem_d;
            aluimm_q <= aluimm_d;
            aluc_q   <= aluc_d;
            dest_q   <= dest_d;
            qa_q     <= qa_d;
            qb_q     <= qb_d;
            imm_q    <= imm_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ewreg      = wreg_q;
    assign em2reg     = m2reg_q;
    assign ewmem      = wmem_q;
    assign ealuimm    = aluimm_q;
    assign ealuc      = aluc_q;
    assign edestReg   = dest_q;
    assign eqa        = qa_q;
    assign eqb        = qb_q;
    assign eimm32     = imm_q;
    assign evalid     = valid_q;
    assign stallCount = cnt_q;

endmodule

// File: tb/tb_idexe_pipe_reg.sv
// Bench for idexe_pipe_reg: directed ID-stage vectors, a slot-level reference
// model compared every cycle, and literal checks at the key points.
module tb_idexe_pipe_reg;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          dvalid, wreg, m2reg, wmem, aluimm, usesRt, flush;
    logic [3:0]    aluc;
    logic [4:0]    destReg, rs, rt;
    logic [DW-1:0] qa, qb, imm32;
    logic          ewreg, em2reg, ewmem, ealuimm, evalid, stall;
    logic [3:0]    ealuc;
    logic [4:0]    edestReg;
    logic [DW-1:0] eqa, eqb, eimm32;
    logic [CW-1:0] stallCount;

    int total = 0;
    int bad   = 0;
    int stalls_seen;

    idexe_pipe_reg #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .dvalid(dvalid), .wreg(wreg), .m2reg(m2reg),
        .wmem(wmem), .aluimm(aluimm), .aluc(aluc), .destReg(destReg),
        .rs(rs), .rt(rt), .usesRt(usesRt), .qa(qa), .qb(qb), .imm32(imm32),
        .flush(flush), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .ealuimm(ealuimm), .ealuc(ealuc), .edestReg(edestReg), .eqa(eqa),
        .eqb(eqb), .eimm32(eimm32), .evalid(evalid), .stall(stall),
        .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the EXE slot as a record plus an integer stall tally.
    typedef struct {
        bit       valid, wreg, m2reg, wmem, aluimm;
        bit [3:0] aluc;
        bit [4:0] dest;
        bit [31:0] qa, qb, imm;
    } slot_t;
    slot_t m_slot = '{default: 0};
    int    m_cnt  = 0;

    function automatic bit model_stall();
        bit dep;
        dep = (m_slot.dest == rs) || (usesRt && m_slot.dest == rt);
        return dvalid && m_slot.valid && m_slot.wreg && m_slot.m2reg && m_slot.dest != 0 && dep;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_slot = '{default: 0};
            m_cnt  = 0;
        end else begin
            bit st;
            st = model_stall();
            if (st && !flush && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
            if (flush || st) m_slot = '{default: 0};
            else m_slot = '{valid: dvalid, wreg: wreg, m2reg: m2reg, wmem: wmem,
                            aluimm: aluimm, aluc: aluc, dest: destReg,
                            qa: qa, qb: qb, imm: imm32};
        end
    end

    always @(negedge clk) begin
        chk("m_evalid",   evalid,     m_slot.valid);
        chk("m_ewreg",    ewreg,      m_slot.wreg);
        chk("m_em2reg",   em2reg,     m_slot.m2reg);
        chk("m_ewmem",    ewmem,      m_slot.wmem);
        chk("m_ealuimm",  ealuimm,    m_slot.aluimm);
        chk("m_ealuc",    ealuc,      m_slot.aluc);
        chk("m_edest",    edestReg,   m_slot.dest);
        chk("m_eqa",      eqa,        m_slot.qa);
        chk("m_eqb",      eqb,        m_slot.qb);
        chk("m_eimm",     eimm32,     m_slot.imm);
        chk("m_stall",    stall,      model_stall());
        chk("m_stallcnt", stallCount, m_cnt);
    end

    task automatic idle();
        dvalid = 0; wreg = 0; m2reg = 0; wmem = 0; aluimm = 0; aluc = 0;
        destReg = 0; rs = 0; rt = 0; usesRt = 0; qa = 0; qb = 0; imm32 = 0; flush = 0;
    endtask

    task automatic set_ins(input bit w, input bit m2r, input logic [4:0] d,
                           input logic [4:0] s, input logic [4:0] t, input bit ur);
        dvalid = 1; wreg = w; m2reg = m2r; destReg = d; rs = s; rt = t; usesRt = ur;
        wmem = 0; aluimm = 0; aluc = 4'b0010; qa = 32'h5; qb = 32'h6; imm32 = 32'h7; flush = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        #1 rst = 1;
        #1;
        @(negedge clk); #1 rst = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        #1;
        chk("rst_evalid", evalid, 0);
        chk("rst_cnt", stallCount, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk); #1 rst = 0;

        // Pass-through
        step();
        dvalid = 1; wreg = 1; aluc = 4'b0010; destReg = 5'd8;
        qa = 32'h11; qb = 32'h22; imm32 = 32'hFFFF_FFFC;
        step();
        chk("pt_ewreg", ewreg, 1);
        chk("pt_ealuc", ealuc, 4'b0010);
        chk("pt_edest", edestReg, 5'd8);
        chk("pt_eqa", eqa, 32'h11);
        chk("pt_eqb", eqb, 32'h22);
        chk("pt_eimm", eimm32, 32'hFFFF_FFFC);
        chk("pt_evalid", evalid, 1);
        chk("pt_stall", stall, 0);

        // Asynchronous reset mid-cycle with outputs loaded
        #2 rst = 1;
        #1;
        chk("arst_ewreg", ewreg, 0);
        chk("arst_eqa", eqa, 0);
        chk("arst_eimm", eimm32, 0);
        chk("arst_evalid", evalid, 0);
        @(negedge clk); #1 rst = 0;
        idle();

        // Load-use: lw $9 then add using $9
        step();
        set_ins(1, 1, 5'd9, 5'd0, 5'd0, 0);
        step();
        set_ins(1, 0, 5'd10, 5'd9, 5'd3, 1);
        qa = 32'hA5;
        #1 chk("lu_stall_hi", stall, 1);
        step();
        chk("lu_bubble_valid", evalid, 0);
        chk("lu_bubble_wreg", ewreg, 0);
        chk("lu_bubble_m2reg", em2reg, 0);
        chk("lu_stall_lo", stall, 0);
        chk("lu_cnt", stallCount, 1);
        step();
        chk("lu_add_valid", evalid, 1);
        chk("lu_add_dest", edestReg, 5'd10);
        chk("lu_add_qa", eqa, 32'hA5);
        chk("lu_cnt2", stallCount, 1);
        idle();

        // Load in EXE, then reset mid-stall
        step();
        set_ins(1, 1, 5'd9, 5'd0, 5'd0, 0);
        step();
        set_ins(1, 0, 5'd10, 5'd9, 5'd0, 0);
        #1 chk("ms_stall_hi", stall, 1);
        rst = 1;
        #1;
        chk("ms_stall_drop", stall, 0);
        chk("ms_evalid", evalid, 0);
        @(negedge clk); #1 rst = 0;
        idle();

        // Non-hazards: $0 destination, rt with usesRt=0, ALU producer
        step(); set_ins(1, 1, 5'd0, 5'd0, 5'd0, 0);
        step(); set_ins(1, 0, 5'd4, 5'd0, 5'd0, 1);
        #1 chk("nh_r0", stall, 0);
        step(); set_ins(1, 1, 5'd9, 5'd0, 5'd0, 0);
        step(); set_ins(1, 0, 5'd4, 5'd1, 5'd9, 0);
        #1 chk("nh_rt_unused", stall, 0);
        step(); set_ins(1, 0, 5'd9, 5'd0, 5'd0, 0);
        step(); set_ins(1, 0, 5'd4, 5'd9, 5'd9, 1);
        #1 chk("nh_alu", stall, 0);
        step();
        chk("nh_cnt", stallCount, 0);
        idle();

        // Flush together with a stall condition, then flush alone
        step(); set_ins(1, 1, 5'd9, 5'd0, 5'd0, 0);
        step(); set_ins(1, 0, 5'd4, 5'd9, 5'd0, 0); flush = 1;
        #1 chk("fl_stall", stall, 1);
        step();
        chk("fl_valid", evalid, 0);
        chk("fl_cnt", stallCount, 0);
        set_ins(1, 1, 5'd12, 5'd0, 5'd0, 0); wmem = 1; aluimm = 1; flush = 1;
        step();
        chk("fa_valid", evalid, 0);
        chk("fa_wreg", ewreg, 0);
        chk("fa_wmem", ewmem, 0);
        chk("fa_aluimm", ealuimm, 0);
        chk("fa_dest", edestReg, 0);
        idle();

        // dvalid=0 loads data but leaves the slot invalid
        step();
        set_ins(1, 0, 5'd7, 5'd0, 5'd0, 0); dvalid = 0; qa = 32'h77;
        step();
        chk("dv0_valid", evalid, 0);
        chk("dv0_qa", eqa, 32'h77);
        idle();

        // Saturation: a self-dependent load stream stalls every other cycle
        do_reset();
        set_ins(1, 1, 5'd9, 5'd9, 5'd0, 0);
        stalls_seen = 0;
        for (int i = 0; i < 44; i++) begin
            step();
            if (stall) stalls_seen++;
        end
        chk("sat_seen_ge20", (stalls_seen >= 20), 1);
        chk("sat_cnt", stallCount, 4'hF);
        step();
        chk("sat_hold", stallCount, 4'hF);
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
